apb_cos_master: RTL and testbench

APB_COS_MASTER -- requirements
Module: apb_cos_master

---
 rtl/apb_cos_master.sv | 134 +++++++++++++
 tb/tb_apb_cos_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cos_master.sv
// ============================================================================
// apb_cos_master : writes an angle step to an APB slave, then reads back the result
// Revision 1.0
// ============================================================================
`default_nettype none

module apb_cos_master #(
    parameter logic [31:0] CTRL_ADDR = 32'h0,
    parameter logic [31:0] OUT_ADDR  = 32'h4,
    parameter int          TIMEOUT   = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req_valid,
    input  logic [31:0] req_step,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        rsp_ready,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    localparam int          CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_ACCESS = 3'd2,
        RD_SETUP  = 3'd3,
        RD_ACCESS = 3'd4,
        RESP      = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     step_q, step_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     data_q, data_d;
    logic            err_q, err_d;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    step_d  = req_step;
                    state_d = WR_SETUP;
                end
            end
            WR_SETUP: begin
                cnt_d   = '0;
                state_d = WR_ACCESS;
            end
            WR_ACCESS: begin
                // PREADY wins over the timeout on the final allowed cycle
                if (PREADY) begin
                    state_d = RD_SETUP;
                end else if (cnt_q == LAST_CNT) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD_SETUP: begin
                cnt_d   = '0;
                state_d = RD_ACCESS;
            end
            RD_ACCESS: begin
                if (PREADY) begin
                    data_d  = PRDATA;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == LAST_CNT) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All outputs decode from registered state only
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign PSEL      = (state_q == WR_SETUP) || (state_q == WR_ACCESS) ||
                       (state_q == RD_SETUP) || (state_q == RD_ACCESS);
    assign PENABLE   = (state_q == WR_ACCESS) || (state_q == RD_ACCESS);
    assign PWRITE    = (state_q == WR_SETUP) || (state_q == WR_ACCESS);
    assign PADDR     = PWRITE ? CTRL_ADDR :
                       ((state_q == RD_SETUP) || (state_q == RD_ACCESS)) ? OUT_ADDR : 32'h0;
    assign PWDATA    = PWRITE ? step_q : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_apb_cos_master.sv
// ============================================================================
// tb_apb_cos_master : vector table, random transactions and corner sequences
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_apb_cos_master;

    logic        PCLK;
    logic        PRESET;
    logic        req_valid;
    logic [31:0] req_step;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_ready;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY;

    apb_cos_master #(.CTRL_ADDR(32'h0), .OUT_ADDR(32'h4), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_step(req_step), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- slave model ----------------
    int          wait_n;
    bit          never_rdy;
    int          acc_cnt;
    logic [31:0] ctrl_reg;
    int          rd_cycles;
    int          idle_viol;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] rd_addr_q[$];

    function automatic logic [31:0] slave_lut(input logic [2:0] k);
        case (k)
            3'd0, 3'd1, 3'd7: return 32'h0000_0001;
            3'd2, 3'd6:       return 32'h0000_0000;
            default:          return 32'hFFFF_FFFF;
        endcase
    endfunction

    assign PREADY = PSEL && PENABLE && !never_rdy && (acc_cnt == wait_n);
    assign PRDATA = (PADDR == 32'h4) ? slave_lut(ctrl_reg[2:0]) : 32'hDEAD_BEEF;

    initial begin
        rd_cycles = 0;
        idle_viol = 0;
    end

    always @(posedge PCLK) begin
        if (PRESET) begin
            acc_cnt  <= 0;
            ctrl_reg <= 32'h0;
        end else begin
            acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
            if (PSEL && PENABLE && PREADY) begin
                if (PWRITE) begin
                    wr_addr_q.push_back(PADDR);
                    wr_data_q.push_back(PWDATA);
                    if (PADDR == 32'h0) ctrl_reg <= PWDATA;
                end else begin
                    rd_addr_q.push_back(PADDR);
                end
            end
            if (PSEL && !PWRITE) rd_cycles <= rd_cycles + 1;
            if (!PSEL && (PENABLE || PWRITE || PADDR != 0 || PWDATA != 0))
                idle_viol <= idle_viol + 1;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] cos_ref(input logic [31:0] k);
        real a;
        int  r;
        a = $cos(3.14159265358979 * real'(k % 8) / 4.0);
        r = int'(a);
        return 32'(r);
    endfunction

    function automatic int lat_ref(input int wt, input bit nr);
        return nr ? 1 + 16 : 4 + 2 * wt;
    endfunction

    // ---------------- checking ----------------
    int n_checks;
    int n_fail;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_txn(input string nm, input logic [31:0] step, input int wt, input bit nr,
                          input int hold, input logic [31:0] ed, input bit ee, input int el,
                          input int ewr, input int erd);
        int          w0, r0, rc0, lat;
        bit          stable;
        logic [31:0] d;
        logic        e;
        w0  = wr_addr_q.size();
        r0  = rd_addr_q.size();
        rc0 = rd_cycles;
        wait_n    = wt;
        never_rdy = nr;
        check({nm, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_step  = step;
        @(posedge PCLK); #1;
        req_valid = 1'b0;
        req_step  = 32'h0;
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(posedge PCLK); #1;
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(el));
        d = rsp_data;
        e = rsp_err;
        check({nm, "_data"}, d, ed);
        check({nm, "_err"}, 32'(e), 32'(ee));
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge PCLK); #1;
            if (!rsp_valid || rsp_data !== d || rsp_err !== e) stable = 1'b0;
        end
        check({nm, "_hold_stable"}, 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
        check({nm, "_idle_after"}, {30'd0, req_ready, rsp_valid}, 32'b10);
        check({nm, "_n_writes"}, 32'(wr_addr_q.size() - w0), 32'(ewr));
        if (ewr > 0 && wr_addr_q.size() > w0) begin
            check({nm, "_wr_addr"}, wr_addr_q[w0], 32'h0);
            check({nm, "_wr_data"}, wr_data_q[w0], step);
        end
        check({nm, "_n_reads"}, 32'(rd_addr_q.size() - r0), 32'(erd));
        if (erd > 0 && rd_addr_q.size() > r0)
            check({nm, "_rd_addr"}, rd_addr_q[r0], 32'h4);
        else
            check({nm, "_no_read_phase"}, 32'(rd_cycles - rc0), 32'd0);
    endtask

    typedef struct {
        logic [31:0] step;
        int          wt;
        bit          nr;
        int          hold;
        logic [31:0] exp_data;
        bit          exp_err;
        int          exp_lat;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          lat, w0, stale;
        bit          found;
        logic [31:0] s;
        int          wt, hold;

        vecs[0] = '{32'd1, 1, 1'b0, 0, 32'h0000_0001, 1'b0, 6,  1, 1};
        vecs[1] = '{32'd8, 0, 1'b0, 5, 32'h0000_0001, 1'b0, 4,  1, 1};
        vecs[2] = '{32'd3, 0, 1'b1, 2, 32'h0000_0000, 1'b1, 17, 0, 0};
        vecs[3] = '{32'd5, 15, 1'b0, 0, 32'hFFFF_FFFF, 1'b0, 34, 1, 1};
        vecs[4] = '{32'd2, 0, 1'b0, 1, 32'h0000_0000, 1'b0, 4,  1, 1};
        vecs[5] = '{32'd4, 2, 1'b0, 0, 32'hFFFF_FFFF, 1'b0, 8,  1, 1};

        n_checks  = 0;
        n_fail    = 0;
        wait_n    = 0;
        never_rdy = 1'b0;
        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_step  = 32'h0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;

        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_apb_ctrl", {29'd0, PSEL, PENABLE, PWRITE}, 32'd0);
        check("reset_paddr", PADDR, 32'h0);
        check("reset_pwdata", PWDATA, 32'h0);
        check("reset_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'h0);

        for (int i = 0; i < 6; i++)
            do_txn($sformatf("vec%0d", i), vecs[i].step, vecs[i].wt, vecs[i].nr, vecs[i].hold,
                   vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_wr, vecs[i].exp_rd);

        for (int i = 0; i < 20; i++) begin
            s    = $urandom;
            wt   = $urandom_range(0, 4);
            hold = $urandom_range(0, 3);
            do_txn($sformatf("rnd%0d", i), s, wt, 1'b0, hold, cos_ref(s), 1'b0,
                   lat_ref(wt, 1'b0), 1, 1);
        end

        // back-to-back requests with the consumer always ready
        wait_n    = 0;
        never_rdy = 1'b0;
        w0        = wr_data_q.size();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_step  = 32'd2;
        @(posedge PCLK); #1;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge PCLK); #1;
            lat++;
        end
        check("b2b_first_data", rsp_data, cos_ref(32'd2));
        check("b2b_no_accept_in_resp", 32'(req_ready), 32'd0);
        req_step = 32'd6;
        @(posedge PCLK); #1;
        check("b2b_gap_idle", {30'd0, req_ready, rsp_valid}, 32'b10);
        @(posedge PCLK); #1;
        req_valid = 1'b0;
        check("b2b_second_setup", {PSEL, PWRITE, PENABLE} == 3'b110 ? PWDATA : 32'hFFFF_FFFF, 32'd6);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge PCLK); #1;
            lat++;
        end
        check("b2b_second_data", rsp_data, cos_ref(32'd6));
        check("b2b_second_err", 32'(rsp_err), 32'd0);
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
        check("b2b_n_writes", 32'(wr_data_q.size() - w0), 32'd2);
        if (wr_data_q.size() >= w0 + 2) begin
            check("b2b_order0", wr_data_q[w0], 32'd2);
            check("b2b_order1", wr_data_q[w0 + 1], 32'd6);
        end

        // reset while the read access is waiting on PREADY
        wait_n    = 3;
        req_valid = 1'b1;
        req_step  = 32'd7;
        @(posedge PCLK); #1;
        req_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (PSEL && PENABLE && !PWRITE) found = 1'b1;
            else begin
                @(posedge PCLK); #1;
            end
        end
        check("rst_mid_reached_rd_access", 32'(found), 32'd1);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        check("rst_mid_psel", 32'(PSEL), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        check("rst_mid_rsp_data", rsp_data, 32'h0);
        stale = 0;
        rsp_ready = 1'b1;
        repeat (20) begin
            @(posedge PCLK); #1;
            if (rsp_valid || PSEL) stale++;
        end
        rsp_ready = 1'b0;
        check("rst_mid_no_stale", 32'(stale), 32'd0);

        check("idle_bus_quiet", 32'(idle_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
